// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the multi-channel pulse timer (timer_multi) and its
// per-channel engine (timer_channel).
//
// Contents:
//   - timer_mode_e : per-channel mode encoding (2 bits per channel on MODE)
//   - sel_width()  : width of the period-write channel selector (LD_SEL)
//
// Mode encoding:
//   2'b00 MODE_ONESHOT  : one-shot, triggers during a pulse are ignored
//   2'b01 MODE_RETRIG   : one-shot, a trigger during a pulse restarts it with
//                         the current period register value
//   2'b10 MODE_PERIODIC : free-running tick generator, reloads the active
//                         period at every terminal count
//   2'b11 MODE_RESERVED : handled exactly like MODE_ONESHOT
//
// Per-edge event priority inside a channel (highest first):
//   reset > ABORT > terminal count > trigger > count
// A trigger that lands on the terminal-count edge is dropped in every mode.
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_RETRIG   = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_RESERVED = 2'b11
    } timer_mode_e;

    // Width of the channel selector on the period write port. A single-channel
    // build still gets a 1-bit selector so the port never collapses to zero width.
    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
// One channel of the multi-channel pulse timer: up-counter, active-period
// shadow, pulse flag and one-cycle expiry strobe, plus an optional trigger
// rising-edge detector.
//
// Configuration macro:
//   TIMER_MULTI_TRG_EDGE_EN : when defined, trg is qualified by a registered
//                             rising-edge detector (a held-high trg yields a
//                             single trigger, taking effect one edge later).
//                             When undefined, trg is level-sensitive.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   trg     in   trigger request
//   mode    in   channel mode (timer_pkg::timer_mode_e encoding)
//   abort   in   synchronous stop, beats terminal count and trigger
//   period  in   current value of this channel's period register
//   out     out  registered pulse flag
//   done    out  registered one-cycle expiry / tick strobe
// -----------------------------------------------------------------------------
module timer_channel
    import timer_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trg,
    input  logic [1:0]       mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] period,
    output logic             out,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] act_r;
    logic             out_r;
    logic             done_r;

    logic [WIDTH-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] act_nxt_s;
    logic             out_nxt_s;
    logic             done_nxt_s;

    logic             trg_s;
    logic             term_s;
    logic             period_ok_s;
    timer_mode_e      mode_s;

`ifdef TIMER_MULTI_TRG_EDGE_EN
    logic trg_q_r;
    logic trg_edge_r;

    // Rising-edge detector on trg; the detected edge is itself registered so
    // the channel sees exactly one trigger per low-to-high transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trg_q_r    <= 1'b0;
            trg_edge_r <= 1'b0;
        end else begin
            trg_q_r    <= trg;
            trg_edge_r <= trg & ~trg_q_r;
        end
    end

    assign trg_s = trg_edge_r;
`else
    assign trg_s = trg;
`endif

    assign mode_s      = timer_mode_e'(mode);
    assign period_ok_s = (period != ZERO);
    // Last counted cycle of the current shot. An active period of zero (only
    // reachable by a periodic reload of P=0) wraps to 2**WIDTH cycles.
    assign term_s      = out_r & (cnt_r == (act_r - ONE));

    // Next-state decode following the per-edge event priority.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        act_nxt_s  = act_r;
        out_nxt_s  = out_r;
        done_nxt_s = 1'b0;

        if (abort) begin
            out_nxt_s = 1'b0;
            cnt_nxt_s = ZERO;
        end else if (term_s) begin
            cnt_nxt_s  = ZERO;
            done_nxt_s = 1'b1;
            case (mode_s)
                MODE_PERIODIC: begin
                    // Keep running; a period written since the last reload
                    // takes effect from here.
                    out_nxt_s = 1'b1;
                    act_nxt_s = period;
                end
                default: begin
                    out_nxt_s = 1'b0;
                end
            endcase
        end else if (trg_s && !out_r) begin
            if (period_ok_s) begin
                out_nxt_s = 1'b1;
                cnt_nxt_s = ZERO;
                act_nxt_s = period;
            end else begin
                // Period register of zero disables the channel.
                out_nxt_s = 1'b0;
            end
        end else if (trg_s && (mode_s == MODE_RETRIG) && period_ok_s) begin
            // Retrigger: restart the shot with the current period, no DONE.
            cnt_nxt_s = ZERO;
            act_nxt_s = period;
        end else if (out_r) begin
            cnt_nxt_s = cnt_r + ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= ZERO;
            act_r  <= DEFAULT_PERIOD;
            out_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            act_r  <= act_nxt_s;
            out_r  <= out_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign out  = out_r;
    assign done = done_r;

endmodule

// File: rtl/timer_multi.sv
// -----------------------------------------------------------------------------
// timer_multi
// NCH-channel programmable pulse timer with WIDTH-bit counters. Each channel
// produces an OUT pulse of its active period after a trigger, in one-shot,
// retriggerable one-shot or periodic mode. Periods are loaded at runtime via
// a shared write port; a write never disturbs a pulse already running.
//
// Configuration macro:
//   TIMER_MULTI_TRG_EDGE_EN : edge-qualified triggers (see timer_channel).
//
// Parameters:
//   NCH            number of channels (1..16)
//   WIDTH          counter / period width
//   DEFAULT_PERIOD reset value of every period register and active shadow
//
// Ports:
//   CLK      in   clock, rising edge
//   R        in   asynchronous active-low reset
//   TRG      in   [NCH]       per-channel trigger
//   MODE     in   [2*NCH]     per-channel mode, channel c on MODE[2c+1:2c]
//   ABORT    in   [NCH]       per-channel synchronous stop
//   LD_WE    in   period write strobe
//   LD_SEL   in   [sel_width] channel index of the period write
//   LD_DATA  in   [WIDTH]     period value to write
//   OUT      out  [NCH]       per-channel pulse (registered)
//   DONE     out  [NCH]       per-channel expiry / tick strobe (registered)
//   BUSY     out  OR of all OUT bits
// -----------------------------------------------------------------------------
module timer_multi
    import timer_pkg::*;
#(
    parameter int               NCH            = 4,
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = 8'hFF
) (
    input  logic                      CLK,
    input  logic                      R,
    input  logic [NCH-1:0]            TRG,
    input  logic [2*NCH-1:0]          MODE,
    input  logic [NCH-1:0]            ABORT,
    input  logic                      LD_WE,
    input  logic [sel_width(NCH)-1:0] LD_SEL,
    input  logic [WIDTH-1:0]          LD_DATA,
    output logic [NCH-1:0]            OUT,
    output logic [NCH-1:0]            DONE,
    output logic                      BUSY
);

    localparam int SEL_W = sel_width(NCH);

    logic [WIDTH-1:0] period_r [NCH];

    // Period register bank. A selector that matches no channel index writes
    // nothing, which is how out-of-range selects are ignored.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            for (int c = 0; c < NCH; c++) begin
                period_r[c] <= DEFAULT_PERIOD;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (LD_WE && (LD_SEL == SEL_W'(c))) begin
                    period_r[c] <= LD_DATA;
                end else begin
                    period_r[c] <= period_r[c];
                end
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        timer_channel #(
            .WIDTH          (WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clk    (CLK),
            .rst_n  (R),
            .trg    (TRG[c]),
            .mode   (MODE[2*c +: 2]),
            .abort  (ABORT[c]),
            .period (period_r[c]),
            .out    (OUT[c]),
            .done   (DONE[c])
        );
    end

    // Every OUT bit is a flop, so BUSY is glitch-free without its own register.
    assign BUSY = |OUT;

endmodule

// File: tb/tb_timer_multi.sv
// -----------------------------------------------------------------------------
// tb_timer_multi
// Self-checking bench for timer_multi (NCH=5 so out-of-range selects exist).
// A reference model tracks each channel as "active + cycles remaining" and
// predicts OUT/DONE/BUSY after every clock edge; directed steps add explicit
// pulse-width, spacing and latency expectations, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_timer_multi;

    localparam int NCH   = 5;
    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic             CLK;
    logic             R;
    logic [NCH-1:0]   TRG;
    logic [2*NCH-1:0] MODE;
    logic [NCH-1:0]   ABORT;
    logic             LD_WE;
    logic [SEL_W-1:0] LD_SEL;
    logic [WIDTH-1:0] LD_DATA;
    logic [NCH-1:0]   OUT;
    logic [NCH-1:0]   DONE;
    logic             BUSY;

    timer_multi #(
        .NCH            (NCH),
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (8'hFF)
    ) dut (
        .CLK     (CLK),
        .R       (R),
        .TRG     (TRG),
        .MODE    (MODE),
        .ABORT   (ABORT),
        .LD_WE   (LD_WE),
        .LD_SEL  (LD_SEL),
        .LD_DATA (LD_DATA),
        .OUT     (OUT),
        .DONE    (DONE),
        .BUSY    (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int             m_per  [NCH];
    int             m_rem  [NCH];
    bit             m_act  [NCH];
    bit             m_done [NCH];
    logic [NCH-1:0] m_prev;
    logic [NCH-1:0] m_edge;
    logic [NCH-1:0] exp_out;
    logic [NCH-1:0] exp_done;
    logic           exp_busy;

    // observation trackers
    int   run_len  [NCH];
    int   last_w   [NCH];
    int   done_cnt [NCH];
    logic fall_done[NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_per[c]     = 255;
            m_rem[c]     = 0;
            m_act[c]     = 1'b0;
            m_done[c]    = 1'b0;
            run_len[c]   = 0;
            fall_done[c] = 1'b0;
        end
        m_prev   = '0;
        m_edge   = '0;
        exp_out  = '0;
        exp_done = '0;
        exp_busy = 1'b0;
    endtask

    // One clock edge of the behavioural model, using the inputs seen at that edge.
    task automatic model_edge();
        logic [NCH-1:0] t_eff;
        int md;
`ifdef TIMER_MULTI_TRG_EDGE_EN
        t_eff  = m_edge;
        m_edge = TRG & ~m_prev;
        m_prev = TRG;
`else
        t_eff = TRG;
`endif
        for (int c = 0; c < NCH; c++) begin
            md = int'(MODE[2*c +: 2]);
            if (ABORT[c]) begin
                m_act[c]  = 1'b0;
                m_rem[c]  = 0;
                m_done[c] = 1'b0;
            end else if (m_act[c] && m_rem[c] == 1) begin
                m_done[c] = 1'b1;
                if (md == 2) m_rem[c] = (m_per[c] == 0) ? 256 : m_per[c];
                else m_act[c] = 1'b0;
            end else begin
                m_done[c] = 1'b0;
                if (t_eff[c] && m_per[c] != 0 && (!m_act[c] || md == 1)) begin
                    m_act[c] = 1'b1;
                    m_rem[c] = m_per[c];
                end else if (m_act[c]) begin
                    m_rem[c] = m_rem[c] - 1;
                end
            end
        end
        if (LD_WE && int'(LD_SEL) < NCH) m_per[int'(LD_SEL)] = int'(LD_DATA);
        for (int c = 0; c < NCH; c++) begin
            exp_out[c]  = m_act[c];
            exp_done[c] = m_done[c];
        end
        exp_busy = |exp_out;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check("model_OUT",  32'(OUT),  32'(exp_out));
        check("model_DONE", 32'(DONE), 32'(exp_done));
        check("model_BUSY", 32'(BUSY), 32'(exp_busy));
        for (int c = 0; c < NCH; c++) begin
            if (DONE[c] === 1'b1) done_cnt[c]++;
            if (OUT[c] === 1'b1) begin
                run_len[c]++;
            end else if (run_len[c] > 0) begin
                last_w[c]    = run_len[c];
                fall_done[c] = DONE[c];
                run_len[c]   = 0;
            end
        end
    endtask

    task automatic trig_pulse(input logic [NCH-1:0] mask);
        TRG = TRG | mask;
        tick();
        TRG = TRG & ~mask;
`ifdef TIMER_MULTI_TRG_EDGE_EN
        tick();
`endif
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        MODE[2*ch +: 2] = m;
    endtask

    task automatic write_p(input int ch, input int data);
        LD_WE   = 1'b1;
        LD_SEL  = SEL_W'(ch);
        LD_DATA = WIDTH'(data);
        tick();
        LD_WE   = 1'b0;
    endtask

    task automatic wait_low(input int ch, input int limit);
        int n;
        n = 0;
        while (OUT[ch] === 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("wait_low_timeout", 32'(OUT[ch]), 32'd0);
    endtask

    task automatic next_done_gap(input int ch, input int limit, output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (DONE[ch] !== 1'b1 && gap < limit);
    endtask

    initial begin
        int g;
        int d;
        R       = 1'b0;
        TRG     = '0;
        MODE    = '0;
        ABORT   = '0;
        LD_WE   = 1'b0;
        LD_SEL  = '0;
        LD_DATA = '0;
        for (int c = 0; c < NCH; c++) begin
            last_w[c]   = 0;
            done_cnt[c] = 0;
        end
        model_reset();

        // reset state
        repeat (3) @(negedge CLK);
        check("rst_out",  32'(OUT),  32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        R = 1'b1;

        // asynchronous reset in the middle of a pulse
        trig_pulse(5'b00001);
        repeat (10) tick();
        check("pre_rst_out0", 32'(OUT[0]), 32'd1);
        @(negedge CLK);
        R = 1'b0;
        #1;
        check("async_rst_out",  32'(OUT),  32'd0);
        check("async_rst_done", 32'(DONE), 32'd0);
        model_reset();
        @(negedge CLK);
        R = 1'b1;

        // default period: 255-cycle pulse, one DONE on the falling edge
        d = done_cnt[0];
        trig_pulse(5'b00001);
        wait_low(0, 300);
        check("dflt_width",     32'(last_w[0]),      32'd255);
        check("dflt_done_fall", 32'(fall_done[0]),   32'd1);
        check("dflt_done_cnt",  32'(done_cnt[0] - d), 32'd1);

        // load and one-shot on channel 1, trigger held 3 cycles
        write_p(1, 5);
        TRG[1] = 1'b1;
        repeat (3) tick();
        TRG[1] = 1'b0;
        wait_low(1, 20);
        check("os_width5", 32'(last_w[1]), 32'd5);
        trig_pulse(5'b00010);
        tick();
        write_p(1, 9);
        wait_low(1, 20);
        check("os_write_midpulse", 32'(last_w[1]), 32'd5);
        trig_pulse(5'b00010);
        wait_low(1, 20);
        check("os_width9", 32'(last_w[1]), 32'd9);

        // retrigger on channel 2
        set_mode(2, 2'b01);
        write_p(2, 4);
        d = done_cnt[2];
        TRG[2] = 1'b1; tick();
        TRG[2] = 1'b0; tick();
        TRG[2] = 1'b1; tick();
        TRG[2] = 1'b0;
        wait_low(2, 20);
        check("rt_width6",    32'(last_w[2]),       32'd6);
        check("rt_done_once", 32'(done_cnt[2] - d), 32'd1);
        // trigger landing on the terminal edge is dropped
        trig_pulse(5'b00100);
        repeat (3) tick();
        TRG[2] = 1'b1;
        tick();
        check("rt_term_out",  32'(OUT[2]),  32'd0);
        check("rt_term_done", 32'(DONE[2]), 32'd1);
        tick();
        check("rt_restart_out", 32'(OUT[2]), 32'd1);
        TRG[2] = 1'b0;
        wait_low(2, 20);

        // periodic on channel 3
        set_mode(3, 2'b10);
        write_p(3, 3);
        trig_pulse(5'b01000);
        next_done_gap(3, 10, g);
        check("per_gap_first", 32'(g), 32'd3);
        next_done_gap(3, 10, g);
        check("per_gap_3",   32'(g),      32'd3);
        check("per_out_high", 32'(OUT[3]), 32'd1);
        write_p(3, 2);
        check("per_no_early_done", 32'(DONE[3]), 32'd0);
        next_done_gap(3, 10, g);
        check("per_gap_old_rest", 32'(g), 32'd2);
        next_done_gap(3, 10, g);
        check("per_gap_new", 32'(g), 32'd2);
        // abort coinciding with terminal count
        tick();
        ABORT[3] = 1'b1;
        tick();
        ABORT[3] = 1'b0;
        check("abort_term_out",  32'(OUT[3]),  32'd0);
        check("abort_term_done", 32'(DONE[3]), 32'd0);
        tick();
        check("abort_stays_off", 32'(OUT[3]), 32'd0);
        set_mode(3, 2'b00);

        // plain abort mid-pulse
        trig_pulse(5'b00010);
        tick();
        ABORT[1] = 1'b1;
        tick();
        ABORT[1] = 1'b0;
        check("abort_out",  32'(OUT[1]),  32'd0);
        check("abort_done", 32'(DONE[1]), 32'd0);

        // period zero disables the channel
        write_p(0, 0);
        trig_pulse(5'b00001);
        check("p0_ignored", 32'(OUT[0]), 32'd0);
        tick();
        check("p0_still_off", 32'(OUT[0]), 32'd0);

        // period one gives a single-cycle pulse
        write_p(0, 1);
        trig_pulse(5'b00001);
        check("p1_out",  32'(OUT[0]),  32'd1);
        check("p1_done", 32'(DONE[0]), 32'd0);
        tick();
        check("p1_fall_out",  32'(OUT[0]),  32'd0);
        check("p1_fall_done", 32'(DONE[0]), 32'd1);
        check("p1_width",     32'(last_w[0]), 32'd1);

        // out-of-range selects leave all period registers alone
        for (int c = 0; c < NCH; c++) write_p(c, 6);
        for (int s = NCH; s < 8; s++) write_p(s, 2);
        MODE = '0;
        trig_pulse(5'b11111);
        for (int c = 0; c < NCH; c++) wait_low(c, 20);
        for (int c = 0; c < NCH; c++) check("oor_width", 32'(last_w[c]), 32'd6);

        // trigger held high for 20 cycles
        write_p(0, 4);
        d = done_cnt[0];
`ifdef TIMER_MULTI_TRG_EDGE_EN
        set_mode(0, 2'b00);
        TRG[0] = 1'b1;
        tick();
        check("edge_lat1", 32'(OUT[0]), 32'd0);
        tick();
        check("edge_lat2", 32'(OUT[0]), 32'd1);
        repeat (18) tick();
        TRG[0] = 1'b0;
        repeat (4) tick();
        check("edge_width",    32'(last_w[0]),       32'd4);
        check("edge_one_done", 32'(done_cnt[0] - d), 32'd1);
`else
        set_mode(0, 2'b01);
        TRG[0] = 1'b1;
        repeat (20) tick();
        check("held_out",     32'(OUT[0]),          32'd1);
        check("held_no_done", 32'(done_cnt[0] - d), 32'd0);
        TRG[0] = 1'b0;
        wait_low(0, 10);
        check("held_width", 32'(last_w[0]), 32'd23);
`endif

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                TRG[c]   = ($urandom_range(0, 5) == 0);
                ABORT[c] = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 49) == 0) MODE = (2*NCH)'($urandom);
            LD_WE   = ($urandom_range(0, 7) == 0);
            LD_SEL  = SEL_W'($urandom_range(0, 7));
            LD_DATA = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 255))
                                                  : WIDTH'($urandom_range(0, 10));
            tick();
        end
        TRG   = '0;
        ABORT = '0;
        LD_WE = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
